// File: rtl/speaker_ctl_if.sv
// Sample-side and codec-side signals of the I2S speaker controller.
// master: the tone generator / codec side. slave: speaker_ctl itself.
interface speaker_ctl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] audio_left;
    logic [DATA_W-1:0] audio_right;
    logic              mute;
    logic              frame_tick;
    logic              audio_mclk;
    logic              audio_lrck;
    logic              audio_sck;
    logic              audio_sdin;

    modport master (
        output audio_left, audio_right, mute,
        input  frame_tick, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );

    modport slave (
        input  audio_left, audio_right, mute,
        output frame_tick, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/speaker_ctl.sv
// I2S serializer for the Pmod audio amplifier/DAC.
// A single 9-bit free-running counter is the only timebase: every codec pin
// is a flop loaded with the decode of the count being loaded, so all pins are
// glitch-free and aligned to the counter.
//   mclk = c[1] (clk/4), sck = c[3] (clk/16), lrck = c[8] (clk/512)
//   p = c[8:4] is the SCK period within the frame; left slot p = 0..15,
//   right slot p = 16..31; k = p mod 16 is the position inside the slot.
// Each slot word goes out MSB-first at k = 1.., one SCK after lrck changes.
// With 16 SCK periods per slot, bit (DATA_W-16) of a 16-bit-or-wider word
// lands at k = 0 of the following slot. Words wider than 16 bits are
// truncated to their top 16 bits.
module speaker_ctl #(
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    speaker_ctl_if.slave bus
);
    localparam int               CNT_W     = 9;
    localparam int               TAIL_IDX  = (DATA_W >= 16) ? (DATA_W - 16) : 0;
    localparam int               SLOT_BITS = (DATA_W < 15) ? DATA_W : 15;
    localparam logic [CNT_W-1:0] LAST_CNT  = '1;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [4:0]        w_pos;
    logic [3:0]        w_bit;
    logic              w_capture;
    logic              w_sdin_next;

    logic [DATA_W-1:0] r_latch_l;
    logic [DATA_W-1:0] r_latch_r;
    // Right-channel tail bit, held so it survives the capture that overwrites r_latch_r.
    logic              r_tail_r;

    logic              r_mclk;
    logic              r_sck;
    logic              r_lrck;
    logic              r_sdin;
    logic              r_tick;

    assign w_cnt_next = r_cnt + 9'd1;
    assign w_pos      = w_cnt_next[8:4];
    assign w_bit      = w_pos[3:0];
    assign w_capture  = (w_cnt_next == '0);

    // Serial data bit owned by SCK period w_pos of the next count.
    always_comb begin
        w_sdin_next = 1'b0;
        if (w_bit == 4'd0) begin
            // Tail of the previous slot: left word's last bit at p = 16,
            // previous frame's right word's last bit at p = 0.
            if (DATA_W >= 16) begin
                w_sdin_next = w_pos[4] ? r_latch_l[TAIL_IDX] : r_tail_r;
            end
        end else begin
            for (int i = 1; i <= SLOT_BITS; i++) begin
                if (w_bit == 4'(i)) begin
                    w_sdin_next = w_pos[4] ? r_latch_r[DATA_W-i] : r_latch_l[DATA_W-i];
                end
            end
        end
    end

    // Frame counter, once-per-frame sample capture and the held right tail bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_latch_l <= '0;
            r_latch_r <= '0;
            r_tail_r  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_capture) begin
                r_latch_l <= bus.mute ? '0 : bus.audio_left;
                r_latch_r <= bus.mute ? '0 : bus.audio_right;
            end
            // r_latch_r is stable through the right slot; the last load here
            // happens at count 511, before the capture edge.
            if (w_cnt_next[CNT_W-1]) begin
                r_tail_r <= r_latch_r[TAIL_IDX];
            end
        end
    end

    // Codec pins and frame_tick, registered from the decode of the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mclk <= 1'b0;
            r_sck  <= 1'b0;
            r_lrck <= 1'b0;
            r_sdin <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_mclk <= w_cnt_next[1];
            r_sck  <= w_cnt_next[3];
            r_lrck <= w_cnt_next[CNT_W-1];
            r_sdin <= w_sdin_next;
            r_tick <= (w_cnt_next == LAST_CNT);
        end
    end

    assign bus.audio_mclk = r_mclk;
    assign bus.audio_sck  = r_sck;
    assign bus.audio_lrck = r_lrck;
    assign bus.audio_sdin = r_sdin;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_speaker_ctl.sv
// Directed bench for speaker_ctl: table of per-frame sample vectors with
// hand-computed captured words, plus hand-written reset sequences.
module tb_speaker_ctl;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;

    speaker_ctl_if #(.DATA_W(DATA_W)) bus ();

    speaker_ctl #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [4:0] outs;
    assign outs = {bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin, bus.frame_tick};

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        m;
        logic        chg_en;
        logic [15:0] chg_l;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs [8];

    int n_tests = 0;
    int n_fail  = 0;

    // model of what the serializer holds: words transmitted this frame,
    // and the right word of the frame before (its last bit opens this frame)
    logic [15:0] m_l1, m_r1, m_r2;
    logic g_sdin, g_lrck, g_sck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one frame from a negedge with cnt == 0 to the next such negedge.
    task automatic run_frame(input logic chg_en, input logic [15:0] chg_l,
                             output logic [31:0] bits, output int div_err, output int edge_err);
        logic [8:0] cv;
        bits     = '0;
        div_err  = 0;
        edge_err = 0;
        for (int c = 0; c < 512; c++) begin
            cv = 9'(c);
            if (bus.audio_mclk !== cv[1] || bus.audio_sck !== cv[3] ||
                bus.audio_lrck !== cv[8] || bus.frame_tick !== (cv == 9'd511))
                div_err++;
            if ((bus.audio_sdin !== g_sdin || bus.audio_lrck !== g_lrck) &&
                !(g_sck === 1'b1 && bus.audio_sck === 1'b0))
                edge_err++;
            g_sdin = bus.audio_sdin;
            g_lrck = bus.audio_lrck;
            g_sck  = bus.audio_sck;
            if (cv[3:0] == 4'd8)
                bits[5'd31 - cv[8:4]] = bus.audio_sdin;
            if (chg_en && c == 100)
                bus.audio_left = chg_l;
            @(negedge clk);
        end
    endtask

    task automatic do_frame(input int idx, input logic [15:0] l, input logic [15:0] r,
                            input logic m, input logic chg_en, input logic [15:0] chg_l,
                            input logic [15:0] exp_l, input logic [15:0] exp_r);
        logic [31:0] bits;
        int div_err, edge_err;
        bus.audio_left  = l;
        bus.audio_right = r;
        bus.mute        = m;
        run_frame(chg_en, chg_l, bits, div_err, edge_err);
        check($sformatf("frame%0d_sdin", idx), bits, {m_r2[0], m_l1, m_r1[15:1]});
        check($sformatf("frame%0d_dividers", idx), 32'(div_err), 32'd0);
        check($sformatf("frame%0d_edge_align", idx), 32'(edge_err), 32'd0);
        m_r2 = m_r1;
        m_l1 = exp_l;
        m_r1 = exp_r;
    endtask

    initial begin
        int err;
        logic [15:0] rl, rr;

        //          l         r         m     chg   chg_l     exp_l     exp_r
        vecs[0] = '{16'h5FFF, 16'hB000, 1'b0, 1'b0, 16'h0000, 16'h5FFF, 16'hB000};
        vecs[1] = '{16'h5FFF, 16'hB001, 1'b0, 1'b1, 16'hB000, 16'hB000, 16'hB001};
        vecs[2] = '{16'h1234, 16'h8001, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 16'h5A5A};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0001};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 16'h8000, 16'h7FFF};
        vecs[6] = '{16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 16'h0000, 16'h0F0F, 16'hF0F1};
        vecs[7] = '{16'h5FFF, 16'hB001, 1'b0, 1'b0, 16'h0000, 16'h5FFF, 16'hB001};

        bus.audio_left  = '0;
        bus.audio_right = '0;
        bus.mute        = 1'b0;
        m_l1 = '0; m_r1 = '0; m_r2 = '0;
        g_sdin = 1'b0; g_lrck = 1'b0; g_sck = 1'b0;

        // power-on reset held for 5 clk
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (outs !== 5'b0) err++;
        end
        check("reset_outputs", 32'(err), 32'd0);
        rst_n = 1'b1;

        // frame i transmits the words captured at the end of frame i-1
        for (int i = 0; i < 8; i++)
            do_frame(i, vecs[i].l, vecs[i].r, vecs[i].m, vecs[i].chg_en, vecs[i].chg_l,
                     vecs[i].exp_l, vecs[i].exp_r);

        // asynchronous reset in the middle of the right slot
        for (int c = 0; c < 300; c++) @(negedge clk);
        check("pre_reset_lrck", 32'(bus.audio_lrck), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_outputs", 32'(outs), 32'd0);
        err = 0;
        repeat (3) begin
            @(negedge clk);
            if (outs !== 5'b0) err++;
        end
        check("reset_hold_outputs", 32'(err), 32'd0);
        rst_n = 1'b1;
        m_l1 = '0; m_r1 = '0; m_r2 = '0;
        g_sdin = 1'b0; g_lrck = 1'b0; g_sck = 1'b0;

        // first frame after reset is all zero; then random samples
        for (int i = 0; i < 4; i++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            do_frame(10 + i, rl, rr, 1'b0, 1'b0, 16'h0000, rl, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
